// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: round-robin arbiter sharing one memory port between two requesters.
// Defining ARB_TIMEOUT_EN adds a watchdog that aborts a grant after TIMEOUT_CYCLES cycles.
module memory_port_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_enable,
    input  logic        req0_readWrite,
    input  logic [14:0] req0_address,
    input  logic [31:0] req0_data_write,
    output logic [31:0] req0_data_read,
    output logic        req0_done,
    output logic        req0_grant,
    input  logic        req1_enable,
    input  logic        req1_readWrite,
    input  logic [14:0] req1_address,
    input  logic [31:0] req1_data_write,
    output logic [31:0] req1_data_read,
    output logic        req1_done,
    output logic        req1_grant,
    output logic        mem_enable,
    output logic        mem_readWrite,
    output logic [14:0] mem_address,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_data_read,
    input  logic        mem_done,
    output logic        arb_timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT0  = 2'd1;
    localparam logic [1:0] GRANT1  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0] state;
    logic       prio;
    logic       win0;
    logic       win1;
    logic       granted;
    logic       expire;

    // prio names the requester that wins a tie
    assign win0    = req0_enable && (!req1_enable || !prio);
    assign win1    = req1_enable && !win0;
    assign granted = (state == GRANT0) || (state == GRANT1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] count;

    assign expire = granted && !mem_done && (count == TIMEOUT_CYCLES - 8'd1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count       <= 8'd0;
            arb_timeout <= 1'b0;
        end else begin
            count       <= granted ? count + 8'd1 : 8'd0;
            arb_timeout <= expire;
        end
    end
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign expire         = 1'b0;
    assign arb_timeout    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            prio           <= 1'b0;
            req0_data_read <= 32'd0;
            req1_data_read <= 32'd0;
            req0_done      <= 1'b0;
            req1_done      <= 1'b0;
            req0_grant     <= 1'b0;
            req1_grant     <= 1'b0;
            mem_enable     <= 1'b0;
            mem_readWrite  <= 1'b0;
            mem_address    <= 15'd0;
            mem_data_write <= 32'd0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        state          <= win0 ? GRANT0 : GRANT1;
                        prio           <= win0;
                        mem_enable     <= 1'b1;
                        req0_grant     <= win0;
                        req1_grant     <= win1;
                        mem_readWrite  <= win0 ? req0_readWrite  : req1_readWrite;
                        mem_address    <= win0 ? req0_address    : req1_address;
                        mem_data_write <= win0 ? req0_data_write : req1_data_write;
                    end
                end
                GRANT0, GRANT1: begin
                    if (mem_done || expire) begin
                        state      <= RELEASE;
                        mem_enable <= 1'b0;
                        req0_grant <= 1'b0;
                        req1_grant <= 1'b0;
                        req0_done  <= (state == GRANT0);
                        req1_done  <= (state == GRANT1);
                        // a write completion keeps the old read data; an abort clears it
                        if (state == GRANT0 && (!mem_done || mem_readWrite))
                            req0_data_read <= mem_done ? mem_data_read : 32'd0;
                        if (state == GRANT1 && (!mem_done || mem_readWrite))
                            req1_data_read <= mem_done ? mem_data_read : 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: random requesters and memory checked against a transaction-level model.
module tb_memory_port_arbiter;
`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO = 8'd4;
    localparam bit TO_ON = 1'b1;
    localparam int MAXW = 5;
`else
    localparam logic [7:0] TO = 8'd255;
    localparam bit TO_ON = 1'b0;
    localparam int MAXW = 4;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] rw = 2'b00;
    logic [14:0] addr [2];
    logic [31:0] wd [2];
    logic [31:0] rd0, rd1;
    logic done0, done1, grant0, grant1;
    logic mem_enable, mem_readWrite, mem_done, arb_timeout;
    logic [14:0] mem_address;
    logic [31:0] mem_data_write, mem_data_read;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    memory_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req0_enable(en[0]), .req0_readWrite(rw[0]), .req0_address(addr[0]),
        .req0_data_write(wd[0]), .req0_data_read(rd0), .req0_done(done0), .req0_grant(grant0),
        .req1_enable(en[1]), .req1_readWrite(rw[1]), .req1_address(addr[1]),
        .req1_data_write(wd[1]), .req1_data_read(rd1), .req1_done(done1), .req1_grant(grant1),
        .mem_enable(mem_enable), .mem_readWrite(mem_readWrite), .mem_address(mem_address),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read), .mem_done(mem_done),
        .arb_timeout(arb_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: who owns the port, who is favoured next, what was latched
    int own = -1;
    int gcnt = 0;
    bit rel = 1'b0;
    bit fav = 1'b0;
    bit edone [2];
    bit eto;
    logic [31:0] erd [2];
    logic lrw = 1'b0;
    logic [14:0] laddr = 15'd0;
    logic [31:0] lwd = 32'd0;

    logic s_reset, s_md;
    logic [1:0] s_en, s_rw;
    logic [14:0] s_addr [2];
    logic [31:0] s_wd [2];
    logic [31:0] s_mrd;

    initial begin
        int wt;
        bit started;
        int w;
        started = 1'b0;
        wt = 0;
        addr[0] = 15'd0; addr[1] = 15'd0;
        wd[0] = 32'd0; wd[1] = 32'd0;
        erd[0] = 32'd0; erd[1] = 32'd0;
        mem_done = 1'b0;
        mem_data_read = 32'd0;
        en = 2'b11;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            s_reset = reset; s_en = en; s_rw = rw; s_addr = addr; s_wd = wd;
            s_md = mem_done; s_mrd = mem_data_read;
            @(posedge clock);
            #1;
            edone[0] = 1'b0; edone[1] = 1'b0; eto = 1'b0;
            if (!s_reset) begin
                own = -1; rel = 1'b0; fav = 1'b0;
                erd[0] = 32'd0; erd[1] = 32'd0;
                lrw = 1'b0; laddr = 15'd0; lwd = 32'd0;
            end else if (own >= 0) begin
                gcnt++;
                if (s_md) begin
                    edone[own] = 1'b1;
                    if (lrw) erd[own] = s_mrd;
                    own = -1; rel = 1'b1;
                end else if (TO_ON && gcnt == int'(TO)) begin
                    edone[own] = 1'b1; erd[own] = 32'd0; eto = 1'b1;
                    own = -1; rel = 1'b1;
                end
            end else if (rel) begin
                rel = 1'b0;
            end else if (s_en != 2'b00) begin
                w = (s_en == 2'b11) ? int'(fav) : (s_en[0] ? 0 : 1);
                own = w; fav = (w == 0); gcnt = 0;
                lrw = s_rw[w]; laddr = s_addr[w]; lwd = s_wd[w];
            end
            check("done0", 32'(done0), 32'(edone[0]));
            check("done1", 32'(done1), 32'(edone[1]));
            check("grant0", 32'(grant0), 32'(own == 0));
            check("grant1", 32'(grant1), 32'(own == 1));
            check("mem_enable", 32'(mem_enable), 32'(own >= 0));
            check("mem_readWrite", 32'(mem_readWrite), 32'(lrw));
            check("mem_address", 32'(mem_address), 32'(laddr));
            check("mem_data_write", mem_data_write, lwd);
            check("data_read0", rd0, erd[0]);
            check("data_read1", rd1, erd[1]);
            check("arb_timeout", 32'(arb_timeout), 32'(eto));
            reset = (cyc < 3) ? 1'b0 : ($urandom_range(0, 249) != 0);
            for (int n = 0; n < 2; n++) begin
                if (edone[n] || (en[n] && own == n && $urandom_range(0, 40) == 0)) begin
                    en[n] = 1'b0;
                end else if (!en[n] && ($urandom_range(0, 2) == 0 || cyc > 2000)) begin
                    en[n] = 1'b1; rw[n] = 1'($urandom); addr[n] = 15'($urandom); wd[n] = $urandom;
                end else if (en[n] && $urandom_range(0, 3) == 0) begin
                    rw[n] = 1'($urandom); addr[n] = 15'($urandom); wd[n] = $urandom;
                end
            end
            mem_data_read = $urandom;
            if (mem_enable) begin
                if (!started) begin
                    started = 1'b1;
                    wt = $urandom_range(0, MAXW);
                end
                if (wt == 0) begin
                    mem_done = 1'b1;
                    started = 1'b0;
                end else begin
                    mem_done = 1'b0;
                    wt--;
                end
            end else begin
                started = 1'b0;
                mem_done = ($urandom_range(0, 7) == 0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
